am_insert_module: RTL and testbench

- Transmit-side counterpart of the per-lane alignment-marker lock and BIP checker.
- One instance per PCS lane, after block distribution and before the PMA gearbox.
- Every i_rf_am_period data blocks it emits one lane-specific 66-bit alignment marker (AM) in place of a data slot and holds off upstream for that slot.
- Each AM carries BIP3 over all bits since the previous AM, plus BIP7 = ~BIP3.

---
 rtl/am_insert_module_pkg.sv | 42 ++++
 rtl/am_insert_module_tx_bip_accumulator.sv | 31 +++
 rtl/am_insert_module.sv | 117 +++++++++++
 tb/tb_am_insert_module.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_insert_module_pkg.sv
// rtl/am_insert_module_pkg.sv - am_pkg: alignment-marker table, sync header and BIP3 block mapping
// Shared between the transmit inserter and the receive-side lock/BIP checker.
package am_pkg;

    localparam int NB_CODED_BLOCK = 66;
    localparam int N_LANES        = 20;
    localparam int NB_LANE_ID     = $clog2(N_LANES);
    localparam int NB_BIP         = 8;
    localparam int NB_AM_MARKERS  = 24;

    localparam logic [1:0] CTRL_SH = 2'b10;

    typedef enum logic {
        AM_SLOT = 1'b0,
        DATA    = 1'b1
    } am_state_t;

    // {M0, M1, M2} per lane; M4..M6 are the bitwise complements
    localparam logic [NB_AM_MARKERS-1:0] AM_TABLE [N_LANES] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    // Payload bit p (p >= 2) lands on BIP[(p-2) mod 8], which is bit (7-k) of every payload byte.
    function automatic logic [NB_BIP-1:0] bip3_of_block(input logic [NB_CODED_BLOCK-1:0] blk);
        logic [7:0]        col;
        logic [NB_BIP-1:0] bip;
        col = '0;
        for (int j = 0; j < 8; j++) begin
            col = col ^ blk[63-8*j -: 8];
        end
        for (int k = 0; k < NB_BIP; k++) begin
            bip[k] = col[7-k];
        end
        bip[3] = bip[3] ^ blk[65];
        bip[4] = bip[4] ^ blk[64];
        return bip;
    endfunction

endpackage

// File: rtl/am_insert_module_tx_bip_accumulator.sv
// rtl/am_insert_module_tx_bip_accumulator.sv - running BIP3 over transmitted blocks, seedable from an AM
module tx_bip_accumulator
    import am_pkg::*;
(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NB_CODED_BLOCK-1:0] i_data,
    input  logic                      i_accumulate,
    input  logic                      i_seed,
    output logic [NB_BIP-1:0]         o_bip3
);

    logic [NB_BIP-1:0] block_bip;

    assign block_bip = bip3_of_block(i_data);

    // Seeding restarts the span with the AM just sent rather than clearing it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_bip3 <= '0;
        end else if (i_enable) begin
            if (i_seed) begin
                o_bip3 <= block_bip;
            end else if (i_accumulate) begin
                o_bip3 <= o_bip3 ^ block_bip;
            end
        end
    end

endmodule

// File: rtl/am_insert_module.sv
// rtl/am_insert_module.sv - per-lane alignment-marker inserter with BIP3/BIP7 generation
// Optional: define AM_INSERT_BIP_ERR_INJECT_EN to add i_rf_bip_err_inject.
module am_insert_module #(
    parameter int NB_CODED_BLOCK = 66,
    parameter int N_LANES        = 20,
    parameter int NB_LANE_ID     = $clog2(N_LANES),
    parameter int NB_AM_PERIOD   = 16,
    parameter int NB_BIP         = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_rf_enable,
    input  logic                      i_valid,
    input  logic [NB_CODED_BLOCK-1:0] i_data,
    input  logic [NB_LANE_ID-1:0]     i_lane_id,
    input  logic [NB_AM_PERIOD-1:0]   i_rf_am_period,
`ifdef AM_INSERT_BIP_ERR_INJECT_EN
    input  logic                      i_rf_bip_err_inject,
`endif
    output logic                      o_ready,
    output logic [NB_CODED_BLOCK-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_am_inserted
);
    import am_pkg::*;

    logic                      slot;
    am_state_t                 state;
    am_state_t                 state_next;
    logic [NB_AM_PERIOD-1:0]   count;
    logic [NB_AM_PERIOD-1:0]   count_next;
    logic [NB_AM_PERIOD-1:0]   period_eff;
    logic [NB_LANE_ID-1:0]     lane_sel;
    logic [NB_AM_MARKERS-1:0]  markers;
    logic [NB_BIP-1:0]         acc_bip3;
    logic [NB_BIP-1:0]         bip_flip;
    logic [NB_BIP-1:0]         tx_bip3;
    logic [NB_BIP-1:0]         tx_bip7;
    logic [NB_CODED_BLOCK-1:0] am_clean;
    logic [NB_CODED_BLOCK-1:0] am_tx;
    logic [NB_CODED_BLOCK-1:0] acc_data;

    assign slot       = i_valid && i_rf_enable;
    assign period_eff = (i_rf_am_period == '0) ? {{(NB_AM_PERIOD-1){1'b0}}, 1'b1} : i_rf_am_period;
    assign o_ready    = (state == DATA);

`ifdef AM_INSERT_BIP_ERR_INJECT_EN
    assign bip_flip = {{(NB_BIP-1){1'b0}}, i_rf_bip_err_inject};
`else
    assign bip_flip = '0;
`endif

    // Out-of-range lane ids fall back to the lane 0 marker.
    assign lane_sel = (32'(i_lane_id) < N_LANES) ? i_lane_id : '0;
    assign markers  = AM_TABLE[lane_sel];
    assign tx_bip3  = acc_bip3 ^ bip_flip;
    assign tx_bip7  = ~acc_bip3 ^ bip_flip;
    assign am_clean = {CTRL_SH, markers, acc_bip3, ~markers, ~acc_bip3};
    assign am_tx    = {CTRL_SH, markers, tx_bip3, ~markers, tx_bip7};

    // The clean AM seeds the accumulator so an injected error costs exactly one BIP mismatch downstream.
    assign acc_data = (state == AM_SLOT) ? am_clean : i_data;

    tx_bip_accumulator u_bip_acc (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_enable     (i_rf_enable),
        .i_data       (acc_data),
        .i_accumulate (slot && (state == DATA)),
        .i_seed       (slot && (state == AM_SLOT)),
        .o_bip3       (acc_bip3)
    );

    // Comparing with >= lets a lowered period force the AM without waiting for a wrap.
    always_comb begin
        state_next = state;
        count_next = count;
        if (i_rf_enable) begin
            case (state)
                AM_SLOT: begin
                    if (i_valid) begin
                        count_next = '0;
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (i_valid) begin
                        count_next = count + 1'b1;
                    end
                    if (count_next >= period_eff) begin
                        state_next = AM_SLOT;
                    end
                end
                default: state_next = AM_SLOT;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= AM_SLOT;
            count         <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_am_inserted <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            o_valid       <= slot;
            o_am_inserted <= slot && (state == AM_SLOT);
            if (slot) begin
                o_data <= (state == AM_SLOT) ? am_tx : i_data;
            end
        end
    end

endmodule

// File: tb/tb_am_insert_module.sv
// tb/tb_am_insert_module.sv - scoreboard bench for am_insert_module (AM_INSERT_BIP_ERR_INJECT_EN aware)
`timescale 1ns/1ps
module tb_am_insert_module;

    logic        clock = 1'b0;
    logic        reset;
    logic        rf_enable;
    logic        valid;
    logic [65:0] data;
    logic [4:0]  lane_id;
    logic [15:0] am_period;
    logic        inj;
    logic        ready;
    logic [65:0] out_data;
    logic        out_valid;
    logic        am_ins;

    int tests = 0;
    int fails = 0;

    logic [65:0] exp_blk[$];
    logic        exp_am[$];
    logic [65:0] am_log[$];
    int          n_out;
    int          n_am_out;
    logic        hold = 1'b0;
    int          hold_valids = 0;
    logic [7:0]  rx_bip;
    int          rx_err = 0;

    logic        m_am;
    int          m_count;
    logic [7:0]  m_bip;

    localparam logic [65:0] ZBLK   = {2'b01, 64'h0};
    localparam logic [65:0] AM_L0  = 66'h2_C168_2100_3E97_DEFF;

    always #5 clock = ~clock;

    am_insert_module dut (
        .i_clock             (clock),
        .i_reset             (reset),
        .i_rf_enable         (rf_enable),
        .i_valid             (valid),
        .i_data              (data),
        .i_lane_id           (lane_id),
        .i_rf_am_period      (am_period),
`ifdef AM_INSERT_BIP_ERR_INJECT_EN
        .i_rf_bip_err_inject (inj),
`endif
        .o_ready             (ready),
        .o_data              (out_data),
        .o_valid             (out_valid),
        .o_am_inserted       (am_ins)
    );

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_bip(input logic [65:0] b);
        logic [7:0] r;
        int t;
        r = '0;
        for (int p = 0; p < 66; p++) begin
            t = (p == 0) ? 3 : (p == 1) ? 4 : (p - 2) % 8;
            r[t] = r[t] ^ b[65-p];
        end
        return r;
    endfunction

    function automatic logic [23:0] model_markers(input logic [4:0] lane);
        case (lane)
            5'd3:    return 24'h4D957B;
            5'd7:    return 24'h7B4566;
            default: return 24'hC16821;
        endcase
    endfunction

    function automatic logic [65:0] model_am(input logic [4:0] lane, input logic [7:0] bip, input logic flip);
        logic [23:0] mk;
        mk = model_markers(lane);
        return {2'b10, mk, bip ^ {7'b0, flip}, ~mk, ~bip ^ {7'b0, flip}};
    endfunction

    function automatic int eff_period(input logic [15:0] p);
        return (p == 16'd0) ? 1 : int'(p);
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            rx_bip = '0;
            n_out = 0;
            n_am_out = 0;
            am_log.delete();
        end else if (out_valid) begin
            if (hold) hold_valids++;
            n_out++;
            if (exp_blk.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: actual %h required none", out_data);
            end else begin
                check("o_data", out_data, exp_blk.pop_front());
                check("o_am_inserted", 66'(am_ins), 66'(exp_am.pop_front()));
            end
            if (am_ins) begin
                if (out_data[39:32] != rx_bip) rx_err++;
                rx_bip = model_bip(out_data);
                n_am_out++;
                am_log.push_back(out_data);
            end else begin
                rx_bip = rx_bip ^ model_bip(out_data);
            end
        end else if (am_ins) begin
            check("am_without_valid", 66'(am_ins), 66'(0));
        end
    end

    task automatic do_slot(input logic [65:0] d, output logic consumed);
        check("o_ready", 66'(ready), 66'(!m_am));
        if (m_am) begin
            exp_blk.push_back(model_am(lane_id, m_bip, inj));
            exp_am.push_back(1'b1);
            m_bip   = model_bip(model_am(lane_id, m_bip, 1'b0));
            m_count = 0;
            m_am    = 1'b0;
            consumed = 1'b0;
        end else begin
            exp_blk.push_back(d);
            exp_am.push_back(1'b0);
            m_bip = m_bip ^ model_bip(d);
            m_count++;
            if (m_count >= eff_period(am_period)) m_am = 1'b1;
            consumed = 1'b1;
        end
        valid = 1'b1;
        data  = d;
        @(posedge clock); #1;
        valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic send(input logic [65:0] d);
        logic c;
        do_slot(d, c);
        if (!c) do_slot(d, c);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b0;
        m_am    = 1'b1;
        m_count = 0;
        m_bip   = '0;
    endtask

    initial begin
        logic [7:0] bip_p4;
        int         n0;
        reset = 1'b1; rf_enable = 1'b0; valid = 1'b0; data = '0;
        lane_id = '0; am_period = 16'd4; inj = 1'b0;
        m_am = 1'b1; m_count = 0; m_bip = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_o_valid", 66'(out_valid), 66'(0));
        check("reset_o_am_inserted", 66'(am_ins), 66'(0));
        check("reset_o_data", out_data, 66'(0));
        check("reset_o_ready", 66'(ready), 66'(0));
        reset = 1'b0;
        rf_enable = 1'b1;
        @(posedge clock); #1;

        // period 4, zero payload: AM, 4 data, AM, 4 data, AM, 2 data
        repeat (10) send(ZBLK);
        check("p4_first_am", am_log[0], AM_L0);
        check("p4_second_bip3", 66'(am_log[1][39:32]), 66'(8'h08));
        check("p4_second_bip7", 66'(am_log[1][7:0]), 66'(8'hF7));
        check("p4_n_out", 66'(n_out), 66'(13));
        check("p4_n_am", 66'(n_am_out), 66'(3));
        bip_p4 = am_log[1][39:32];

        am_period = 16'd3;
        do_reset();
        repeat (4) send(ZBLK);
        check("p3_second_bip3", 66'(am_log[1][39:32]), 66'(8'h18));
        check("p3_vs_p4_diff", 66'(am_log[1][39:32] ^ bip_p4), 66'(8'h10));

        // random payload, lane 7, then an enable hold mid-period
        am_period = 16'd6;
        lane_id = 5'd7;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            send({2'($urandom_range(1, 2)), $urandom(), $urandom()});
        end
        rf_enable = 1'b0;
        hold = 1'b1;
        valid = 1'b1;
        data = {2'b10, 64'hDEAD_BEEF_0BAD_F00D};
        repeat (10) @(posedge clock);
        #1;
        valid = 1'b0;
        hold = 1'b0;
        rf_enable = 1'b1;
        @(posedge clock); #1;
        check("hold_no_valid", 66'(hold_valids), 66'(0));
        for (int i = 0; i < 10; i++) begin
            send({2'($urandom_range(1, 2)), $urandom(), $urandom()});
        end

        // period lowered from 100 to 5 at count 50
        am_period = 16'd100;
        lane_id = 5'd3;
        do_reset();
        repeat (50) send({2'b01, $urandom(), $urandom()});
        am_period = 16'd5;
        if (m_count >= eff_period(am_period)) m_am = 1'b1;
        @(posedge clock); #1;
        n0 = n_am_out;
        send(ZBLK);
        check("period_drop_am", 66'(n_am_out), 66'(n0 + 1));

        // reset mid-period; out-of-range lane falls back to lane 0
        repeat (2) send(ZBLK);
        lane_id = 5'd25;
        am_period = 16'd4;
        do_reset();
        send(ZBLK);
        check("reset_mid_am", am_log[0], AM_L0);

`ifdef AM_INSERT_BIP_ERR_INJECT_EN
        lane_id = 5'd0;
        do_reset();
        repeat (4) send(ZBLK);
        inj = 1'b1;
        send(ZBLK);
        inj = 1'b0;
        repeat (5) send(ZBLK);
        check("inject_bip3", 66'(am_log[1][39:32]), 66'(8'h09));
        check("inject_bip7", 66'(am_log[1][7:0]), 66'(8'hF6));
        check("inject_next_bip3", 66'(am_log[2][39:32]), 66'(8'h08));
        check("rx_err_count", 66'(rx_err), 66'(1));
`else
        check("rx_err_count", 66'(rx_err), 66'(0));
`endif

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", 66'(exp_blk.size()), 66'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
